// File: rtl/program_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the program loader.
interface program_loader_if #(
    parameter int unsigned DATA_WIDTH    = 20,
    parameter int unsigned ADDRESS_WIDTH = 8
);
    logic                     in_valid;
    logic [7:0]               in_byte;
    logic                     in_ready;
    logic                     imem_we;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0]    imem_wdata;
    logic                     cpu_rst;
    logic                     load_done;
    logic                     load_error;
    logic [ADDRESS_WIDTH:0]   words_loaded;

    modport master (
        output in_valid, in_byte,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_rst, load_done, load_error, words_loaded
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_rst, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory writes, core held in reset until done.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned DATA_WIDTH     = 20,
    parameter int unsigned ADDRESS_WIDTH  = 8,
    parameter int unsigned BYTES_PER_WORD = 3
) (
    input  logic            clk,
    input  logic            rst,
    program_loader_if.slave bus
);
    localparam int unsigned CAPACITY  = 1 << ADDRESS_WIDTH;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned WORD_BITS = 8 * BYTES_PER_WORD;
    localparam int unsigned SHIFT_W   = WORD_BITS - 8;

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
`ifdef LOADER_CHECKSUM_EN
        , S_CHK  = 3'd6
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END_DATA = S_CHK;
`else
    localparam state_t S_END_DATA = S_FLUSH;
`endif

    state_t                   r_state;
    state_t                   w_next;
    logic [LEN_W-1:0]         r_len;
    logic [CNT_W-1:0]         r_byte_cnt;
    logic [SHIFT_W-1:0]       r_shift;
    logic [ADDRESS_WIDTH:0]   r_words;
    logic                     r_imem_we;
    logic [ADDRESS_WIDTH-1:0] r_imem_addr;
    logic [DATA_WIDTH-1:0]    r_imem_wdata;
    logic                     r_cpu_rst;
    logic                     r_load_done;
    logic                     r_load_error;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               r_csum;
`endif

    logic                     w_in_ready;
    logic                     w_accept;
    logic                     w_word_done;
    logic                     w_last_word;
    logic [LEN_W-1:0]         w_hdr_len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HDR_HI;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HDR_HI: if (w_accept) w_next = S_HDR_LO;
            S_HDR_LO: begin
                if (w_accept) begin
                    if (32'(w_hdr_len) > CAPACITY) w_next = S_ERROR;
                    else if (w_hdr_len == '0)      w_next = S_END_DATA;
                    else                           w_next = S_DATA;
                end
            end
            S_DATA:   if (w_word_done && w_last_word) w_next = S_END_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:    if (w_accept) w_next = (bus.in_byte == r_csum) ? S_FLUSH : S_ERROR;
`endif
            S_FLUSH:  w_next = S_DONE;
            default:  w_next = r_state;
        endcase
    end

    // Output decode: handshake ready and per-cycle strobes
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_HDR_HI, S_HDR_LO, S_DATA: w_in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:                      w_in_ready = 1'b1;
`endif
            default:                    w_in_ready = 1'b0;
        endcase
        if (rst) w_in_ready = 1'b0;
        w_accept    = bus.in_valid && w_in_ready;
        w_word_done = w_accept && (r_state == S_DATA) &&
                      (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
        w_last_word = (32'(r_words) + 32'd1) == 32'(r_len);
        w_hdr_len   = {r_len[15:8], bus.in_byte};
    end

    // Datapath: header capture, word assembly, memory write port and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len        <= '0;
            r_byte_cnt   <= '0;
            r_shift      <= '0;
            r_words      <= '0;
            r_imem_we    <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_cpu_rst    <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_imem_we <= w_word_done;
            if (w_accept && r_state == S_HDR_HI) r_len[15:8] <= bus.in_byte;
            if (w_accept && r_state == S_HDR_LO) r_len[7:0]  <= bus.in_byte;
            if (w_accept && r_state == S_DATA) begin
`ifdef LOADER_CHECKSUM_EN
                r_csum <= r_csum ^ bus.in_byte;
`endif
                if (w_word_done) begin
                    r_byte_cnt   <= '0;
                    r_imem_wdata <= DATA_WIDTH'({r_shift, bus.in_byte});
                    r_imem_addr  <= r_words[ADDRESS_WIDTH-1:0];
                    r_words      <= r_words + (ADDRESS_WIDTH + 1)'(1);
                end else begin
                    r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                    r_shift    <= {r_shift[SHIFT_W-9:0], bus.in_byte};
                end
            end
            // FLUSH lasts exactly one cycle, after the final write strobe
            if (r_state == S_FLUSH) begin
                r_load_done <= 1'b1;
                r_cpu_rst   <= 1'b0;
            end
            if (w_next == S_ERROR) r_load_error <= 1'b1;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_imem_wdata;
    assign bus.cpu_rst      = r_cpu_rst;
    assign bus.load_done    = r_load_done;
    assign bus.load_error   = r_load_error;
    assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: streams are parsed by a list-level model and checked write by write.
module tb_program_loader;
    localparam int unsigned DW  = 20;
    localparam int unsigned AW  = 8;
    localparam int unsigned CAP = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_loader_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    program_loader #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .BYTES_PER_WORD(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit order_viol = 1'b0;

    logic [7:0]    stim[$];
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_data[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    bit            exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every memory write; the core must still be in reset when it happens
    always @(negedge clk) begin
        if (bus.imem_we) begin
            obs_addr.push_back(bus.imem_addr);
            obs_data.push_back(bus.imem_wdata);
            if (!bus.cpu_rst) order_viol = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: parse the byte list into expected writes and the error verdict
    function automatic void build_expect();
        int         len;
        logic [7:0] x;
        logic [23:0] word;
        exp_addr.delete();
        exp_data.delete();
        exp_err = 1'b0;
        len = (int'(stim[0]) << 8) | int'(stim[1]);
        if (len > int'(CAP)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < len; w++) begin
            word = {stim[2+3*w], stim[3+3*w], stim[4+3*w]};
            exp_addr.push_back(AW'(w));
            exp_data.push_back(word[DW-1:0]);
            x = x ^ stim[2+3*w] ^ stim[3+3*w] ^ stim[4+3*w];
        end
`ifdef LOADER_CHECKSUM_EN
        if (stim[2+3*len] != x) exp_err = 1'b1;
`endif
    endfunction

    function automatic void add_csum(input logic [7:0] flip);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
        stim.push_back(x ^ flip);
`else
        if (flip != 8'h00) stim.push_back(8'h00);
`endif
    endfunction

    function automatic void make_random(input int len);
        stim.delete();
        stim.push_back(8'(len >> 8));
        stim.push_back(8'(len));
        for (int i = 0; i < 3 * len; i++) stim.push_back(8'($urandom));
        add_csum(8'h00);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", bus.in_ready, 0);
        check("rst_words", bus.words_loaded, 0);
        check("rst_cpu_rst", bus.cpu_rst, 1);
        check("rst_done", bus.load_done, 0);
        obs_addr.delete();
        obs_data.delete();
        rst = 1'b0;
        #1;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic drive(input int mode, output int last_acc);
        int i = 0;
        int budget = 0;
        bit v;
        bit rdy;
        last_acc = -100;
        while (i < stim.size()) begin
            @(negedge clk);
            case (mode)
                0:       v = 1'b1;
                1:       v = (budget % 2) == 0;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            bus.in_valid = v;
            bus.in_byte  = v ? stim[i] : 8'($urandom);
            #1;
            rdy = bus.in_ready;
            if (v && rdy) begin
                last_acc = cyc;
                i++;
            end
            budget++;
            if (budget > 4 * stim.size() + 50) begin
                check("drive_timeout", i, stim.size());
                break;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run_case(input string name, input int mode);
        int last_acc;
        int seen = -1;
        int nwr;
        build_expect();
        drive(mode, last_acc);
        for (int k = 0; k < 64; k++) begin
            if (bus.load_done || bus.load_error) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, seen - last_acc, exp_err ? 1 : 2);
        check({name, "_done"}, bus.load_done, !exp_err);
        check({name, "_error"}, bus.load_error, exp_err);
        check({name, "_cpu_rst"}, bus.cpu_rst, exp_err);
        check({name, "_words"}, bus.words_loaded, exp_addr.size());
        // Terminal states refuse further bytes and never write again
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'($urandom);
        #1;
        check({name, "_ready_term"}, bus.in_ready, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        nwr = obs_addr.size();
        check({name, "_nwr"}, nwr, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < nwr; i++) begin
            check({name, "_addr"}, obs_addr[i], exp_addr[i]);
            check({name, "_data"}, obs_data[i], exp_data[i]);
        end
    endtask

    initial begin
        int last_acc;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        do_reset();
        check("reset_ready", bus.in_ready, 1);
        check("reset_we", bus.imem_we, 0);
        check("reset_addr", bus.imem_addr, 0);
        check("reset_wdata", bus.imem_wdata, 0);
        check("reset_error", bus.load_error, 0);

        stim = '{8'h00, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'hF1, 8'h23, 8'h45};
        add_csum(8'h00);
        run_case("b2b", 0);
        if (obs_data.size() >= 2) begin
            check("b2b_word0", obs_data[0], 32'hABCDE);
            check("b2b_word1", obs_data[1], 32'h12345);
        end

        do_reset();
        run_case("toggle", 1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        stim = '{8'h00, 8'h02, 8'h0A, 8'hBC, 8'hDE, 8'hF1, 8'h23, 8'h45};
        add_csum(8'h01);
        run_case("bad_csum", 0);
`endif

        do_reset();
        stim = '{8'h00, 8'h00};
        add_csum(8'h00);
        run_case("empty", 0);

        do_reset();
        stim = '{8'h01, 8'h01};
        run_case("too_long", 0);

        do_reset();
        make_random(int'(CAP));
        run_case("full", 2);

        do_reset();
        stim = '{8'h00, 8'h02, 8'h0A, 8'hBC};
        drive(0, last_acc);
        check("abort_nowr", obs_addr.size(), 0);
        do_reset();
        stim = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h07};
        add_csum(8'h00);
        run_case("after_abort", 0);
        if (obs_data.size() >= 1) check("after_abort_word", obs_data[0], 32'h10007);

        do_reset();
        make_random(2);
        stim = stim[0:5];
        drive(0, last_acc);
        do_reset();
        check("abort_words", bus.words_loaded, 0);

        for (int it = 0; it < 6; it++) begin
            do_reset();
            make_random(int'($urandom_range(1, 30)));
            run_case("rand", int'($urandom_range(0, 2)));
        end

        check("cpu_rst_order", order_viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
